bin_to_bcd: RTL and testbench

//  Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.

---
 rtl/bin_to_bcd_pkg.sv | 26 ++
 rtl/bin_to_bcd_add3.sv | 13 +
 rtl/bin_to_bcd.sv | 119 +++++++++++
 tb/tb_bin_to_bcd.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display blocks
// downstream of it (segment decode, anode scan).
//   state_e     : converter FSM state encodings
//   BCD_NIBBLE  : bits per BCD digit
//   digits_ok() : true when DIGITS decimal digits can hold every WIDTH-bit value
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_NIBBLE = 4;

  // 10**d > 2**w - 1, evaluated wide enough for any practical WIDTH.
  function automatic bit digits_ok(input int w, input int d);
    logic [127:0] p10;
    logic [127:0] lim;
    p10 = 128'd1;
    for (int i = 0; i < d; i++) p10 = p10 * 128'd10;
    lim = (128'd1 << w) - 128'd1;
    return p10 > lim;
  endfunction

endpackage

// File: rtl/bin_to_bcd_add3.sv
// Combinational double-dabble digit correction.
//   in_i  : BCD nibble before the shift
//   out_o : in_i + 3 when in_i >= 5, else in_i (4-bit arithmetic)
module bin_to_bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] in_i,
  output logic [BCD_NIBBLE-1:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one conversion in flight.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request conversion of bin; honoured only in IDLE or DONE
//   bin      : unsigned WIDTH-bit value, captured when start is accepted
//   busy     : high while the WIDTH shift steps run
//   done     : one-cycle pulse when bcd/blank carry a new result
//   bcd      : packed BCD, digit k = bcd[4k+3:4k], digit 0 = units
//   blank    : 1 = digit k is a leading zero; digit 0 is never blanked
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]            blank
);

  localparam int SW = BCD_NIBBLE * DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bin_to_bcd: DIGITS too small for WIDTH");
  end

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [SW-1:0]                  scratch_q;
  logic [SW-1:0]                  adj;
  logic [SW-1:0]                  scratch_d;
  logic                           busy_q;
  logic                           done_q;
  logic [BCD_NIBBLE*DIGITS-1:0]   bcd_q;
  logic [DIGITS-1:0]              blank_q;
  logic [DIGITS-1:0]              blank_d;

  // Scratch layout: {digit DIGITS-1 .. digit 0, binary remainder}.
  // Corrections look at the nibbles before this cycle's shift.
  assign adj[WIDTH-1:0] = scratch_q[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bin_to_bcd_add3 u_add3 (
      .in_i  (scratch_q[WIDTH+BCD_NIBBLE*g +: BCD_NIBBLE]),
      .out_o (adj[WIDTH+BCD_NIBBLE*g +: BCD_NIBBLE])
    );
  end

  assign scratch_d = adj << 1;

  // Leading-zero mask of the result about to be registered.
  always_comb begin
    logic zero_run;
    // NOTE: every variable written here gets a value on every path, otherwise
    // synthesis infers a latch to hold the old one.
    blank_d  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (scratch_d[WIDTH+BCD_NIBBLE*k +: BCD_NIBBLE] == '0);
      blank_d[k] = zero_run;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      scratch_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            scratch_q <= SW'(bin);
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scratch_d[SW-1:WIDTH];
            blank_q <= blank_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and random checks of bin_to_bcd (WIDTH=16, DIGITS=5).
module tb_bin_to_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int checks;
  int errors;

  bin_to_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference built from decimal division, independent of double dabble.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input logic [19:0] b);
    logic [4:0] m;
    logic       z;
    m = '0;
    z = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      z    = z & (b[4*k +: 4] == 4'd0);
      m[k] = z;
    end
    return m;
  endfunction

  // Called at a negedge. Issues start for one edge, then waits (bounded) for
  // done; reports latency in cycles after the accepting edge and busy count.
  task automatic launch_and_wait(input logic [15:0] b, output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'hDEAD;
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_conv(input string tag, input logic [15:0] b);
    int lat, bc;
    logic [19:0] eb;
    eb = ref_bcd(b);
    launch_and_wait(b, lat, bc);
    check({tag, "_latency"}, lat, 17);
    check({tag, "_busy_cycles"}, bc, 16);
    check({tag, "_bcd"}, bcd, eb);
    check({tag, "_blank"}, blank, ref_blank(eb));
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat, bc, ndone, last_done, gap, min_gap, cyc;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin    = '0;

    // 1. Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 20'h00000);
    check("rst_blank", blank, 5'b11110);

    // 2-3. Directed values
    run_conv("c1234", 16'd1234);
    check("c1234_bcd_lit", bcd, 20'h01234);
    check("c1234_blank_lit", blank, 5'b10000);
    run_conv("c65535", 16'd65535);
    check("c65535_bcd_lit", bcd, 20'h65535);
    check("c65535_blank_lit", blank, 5'b00000);
    run_conv("c0", 16'd0);
    check("c0_blank_lit", blank, 5'b11110);
    run_conv("c10000", 16'd10000);
    check("c10000_bcd_lit", bcd, 20'h10000);

    // 4. start during SHIFT is ignored
    start = 1'b1;
    bin   = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3 || i == 4) begin
        start = 1'b1;
        bin   = 16'd500;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
    end
    start = 1'b0;
    check("ign_done_count", ndone, 1);
    check("ign_bcd", bcd, 20'h00009);
    check("ign_busy", busy, 0);

    // 5. start in the DONE cycle: back-to-back conversion
    launch_and_wait(16'd3, lat, bc);
    check("b2b_first_latency", lat, 17);
    check("b2b_first_bcd", bcd, 20'h00003);
    launch_and_wait(16'd42, lat, bc);
    check("b2b_second_latency", lat, 17);
    check("b2b_second_bcd", bcd, 20'h00042);
    check("b2b_second_blank", blank, 5'b11100);
    @(negedge clk);

    // 6. Reset mid-conversion abandons it
    start = 1'b1;
    bin   = 16'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd, 20'h00000);
    check("midrst_blank", blank, 5'b11110);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_conv("c777", 16'd777);
    check("c777_bcd_lit", bcd, 20'h00777);

    // Random values, start held high so conversions run back-to-back
    min_gap   = 1000;
    last_done = -1;
    ndone     = 0;
    cyc       = 0;
    start     = 1'b1;
    bin       = 16'($urandom);
    while (ndone < 1000 && cyc < 20000) begin
      logic [15:0] cur;
      cur = bin;
      @(posedge clk);
      #1;
      // bin accepted at this edge if it was in IDLE/DONE; track via busy rising
      if (busy && !done) begin
        // accepted: wait for result while changing bin to prove no re-sampling
        bin = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          cyc++;
          if (done) break;
        end
        if (!done) begin
          check("rnd_timeout", 0, 1);
          break;
        end
        check("rnd_bcd", bcd, ref_bcd(cur));
        check("rnd_blank", blank, ref_blank(ref_bcd(cur)));
        if (last_done >= 0) begin
          gap = cyc - last_done;
          if (gap < min_gap) min_gap = gap;
        end
        last_done = cyc;
        ndone++;
      end else begin
        cyc++;
      end
    end
    start = 1'b0;
    check("rnd_count", ndone, 1000);
    check("rnd_min_gap_ge17", (min_gap >= 17) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
